// File: rtl/mul_sequencer_if.sv
// rtl/mul_sequencer_if.sv - EX-stage multiply request/response bundle
interface mul_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start_mulE;
  logic [1:0]      mul_op;
  logic [XLEN-1:0] srcA_E;
  logic [XLEN-1:0] srcB_E;
  logic [4:0]      rdE;
  logic            stall_mul;
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_result;
  logic [4:0]      mul_rd;

  modport master (
    output start_mulE, mul_op, srcA_E, srcB_E, rdE,
    input  stall_mul, mul_busy, mul_done, mul_result, mul_rd
  );

  modport slave (
    input  start_mulE, mul_op, srcA_E, srcB_E, rdE,
    output stall_mul, mul_busy, mul_done, mul_result, mul_rd
  );
endinterface

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - iterative shift-add RV32 multiply sequencer with pipeline stall
// MUL_RADIX4_EN selects 2 multiplier bits per step (16 RUN cycles) instead of 1 (32).
module mul_sequencer #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  mul_sequencer_if.slave bus
);
  localparam int W2 = 2 * XLEN;
  localparam logic [W2-1:0]   ONE_W2 = 1;
  localparam logic [XLEN-1:0] ONE_X  = 1;
`ifdef MUL_RADIX4_EN
  localparam logic [4:0] LAST_STEP = 5'd15;
`else
  localparam logic [4:0] LAST_STEP = 5'd31;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d, mul_rd_q, mul_rd_d, cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] mplier_q, mplier_d, result_q, result_d;
  logic [W2-1:0]   mcand_q, mcand_d, acc_q, acc_d;
`ifdef MUL_RADIX4_EN
  logic [W2-1:0]   mcand3_q, mcand3_d;
`endif

  logic            a_sgn, b_sgn, stall_c;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [W2-1:0]   acc_step, product;

  // MUL/MULH treat both operands as signed, MULHSU only rs1, MULHU neither
  assign a_sgn = (bus.mul_op != 2'b11);
  assign b_sgn = ~bus.mul_op[1];
  assign mag_a = (a_sgn && bus.srcA_E[XLEN-1]) ? (~bus.srcA_E + ONE_X) : bus.srcA_E;
  assign mag_b = (b_sgn && bus.srcB_E[XLEN-1]) ? (~bus.srcB_E + ONE_X) : bus.srcB_E;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    mul_rd_d = mul_rd_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    mplier_d = mplier_q;
    result_d = result_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
`ifdef MUL_RADIX4_EN
    mcand3_d = mcand3_q;
`endif
    acc_step = acc_q;
    product  = '0;
    stall_c  = 1'b0;
    case (state_q)
      IDLE: begin
        stall_c = bus.start_mulE;
        if (bus.start_mulE) begin
          op_d     = bus.mul_op;
          rd_d     = bus.rdE;
          neg_d    = (a_sgn & bus.srcA_E[XLEN-1]) ^ (b_sgn & bus.srcB_E[XLEN-1]);
          mcand_d  = {{XLEN{1'b0}}, mag_a};
          mplier_d = mag_b;
`ifdef MUL_RADIX4_EN
          mcand3_d = {{XLEN{1'b0}}, mag_a} + {{(XLEN-1){1'b0}}, mag_a, 1'b0};
`endif
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        stall_c = 1'b1;
`ifdef MUL_RADIX4_EN
        case (mplier_q[1:0])
          2'b01:   acc_step = acc_q + mcand_q;
          2'b10:   acc_step = acc_q + (mcand_q << 1);
          2'b11:   acc_step = acc_q + mcand3_q;
          default: acc_step = acc_q;
        endcase
        mcand_d  = mcand_q << 2;
        mcand3_d = mcand3_q << 2;
        mplier_d = mplier_q >> 2;
`else
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
`endif
        acc_d = acc_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_STEP) begin
          // Result is registered on the way into DONE so it is stable for the whole DONE cycle
          product  = neg_q ? (~acc_step + ONE_W2) : acc_step;
          result_d = (op_q == 2'b00) ? product[XLEN-1:0] : product[W2-1:XLEN];
          mul_rd_d = rd_q;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      mul_rd_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      mplier_q <= '0;
      result_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
`ifdef MUL_RADIX4_EN
      mcand3_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      mul_rd_q <= mul_rd_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
`ifdef MUL_RADIX4_EN
      mcand3_q <= mcand3_d;
`endif
    end
  end

  assign bus.stall_mul  = stall_c;
  assign bus.mul_busy   = (state_q != IDLE);
  assign bus.mul_done   = (state_q == DONE);
  assign bus.mul_result = result_q;
  assign bus.mul_rd     = mul_rd_q;
endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - scoreboard bench for mul_sequencer with directed vectors
module tb_mul_sequencer;
`ifdef MUL_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  mul_sequencer_if #(.XLEN(32)) bus ();

  mul_sequencer #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.mul_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected mul_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("mul_result", bus.mul_result, e.res);
        check("mul_rd", bus.mul_rd, e.rd);
        check("done cycle", cyc, e.cyc);
      end
    end
  end

  task automatic run_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res, input string name);
    exp_t e;
    int   stall_cnt;
    bit   done_seen;
    @(posedge clk); #1;
    bus.start_mulE = 1'b1;
    bus.mul_op     = op;
    bus.srcA_E     = a;
    bus.srcB_E     = b;
    bus.rdE        = rd;
    e.res = exp_res;
    e.rd  = rd;
    e.cyc = cyc + LAT;
    sb_q.push_back(e);
    @(negedge clk);
    check({name, " stall at T"}, bus.stall_mul, 1);
    stall_cnt = 1;
    @(posedge clk); #1;
    bus.start_mulE = 1'b0;
    bus.srcA_E     = 32'hDEADBEEF;
    bus.srcB_E     = 32'h0BADF00D;
    done_seen = 1'b0;
    for (int i = 0; i < 100 && !done_seen; i++) begin
      @(negedge clk);
      if (bus.mul_done) done_seen = 1'b1;
      else if (bus.stall_mul) stall_cnt++;
    end
    check({name, " done seen"}, done_seen, 1);
    check({name, " stall cycles"}, stall_cnt, LAT);
    check({name, " stall in DONE"}, bus.stall_mul, 0);
  endtask

  initial begin
    int t0;
    bus.start_mulE = 1'b0;
    bus.mul_op     = 2'b00;
    bus.srcA_E     = '0;
    bus.srcB_E     = '0;
    bus.rdE        = '0;

    @(negedge clk);
    check("reset stall_mul", bus.stall_mul, 0);
    check("reset mul_busy", bus.mul_busy, 0);
    check("reset mul_done", bus.mul_done, 0);
    check("reset mul_result", bus.mul_result, 0);
    check("reset mul_rd", bus.mul_rd, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_mul(2'b00, 32'd7,        32'd6,        5'd5,  32'h0000002A, "MUL 7x6");
    run_mul(2'b01, 32'h80000000, 32'h80000000, 5'd10, 32'h40000000, "MULH min*min");
    run_mul(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'h00000000, "MULH -1*-1");
    run_mul(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'h00000001, "MUL -1*-1");
    run_mul(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFE, "MULHU max*max");
    run_mul(2'b10, 32'hFFFFFFFF, 32'h00000002, 5'd14, 32'hFFFFFFFF, "MULHSU -1*2");
    run_mul(2'b01, 32'h80000000, 32'h7FFFFFFF, 5'd15, 32'hC0000000, "MULH min*maxpos");
    run_mul(2'b11, 32'h00010000, 32'h00010000, 5'd0,  32'h00000001, "MULHU rd0");

    // Reset during RUN cycle 10
    @(posedge clk); #1;
    bus.start_mulE = 1'b1;
    bus.mul_op     = 2'b00;
    bus.srcA_E     = 32'd9;
    bus.srcB_E     = 32'd9;
    bus.rdE        = 5'd3;
    @(posedge clk); #1;
    bus.start_mulE = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrun reset stall_mul", bus.stall_mul, 0);
    check("midrun reset mul_busy", bus.mul_busy, 0);
    check("midrun reset mul_done", bus.mul_done, 0);
    check("midrun reset mul_result", bus.mul_result, 0);
    check("midrun reset mul_rd", bus.mul_rd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_mul(2'b00, 32'd7, 32'd6, 5'd31, 32'h0000002A, "MUL after reset");

    // Back-to-back with start held across DONE; srcA disturbed during RUN
    @(posedge clk); #1;
    t0 = cyc;
    bus.start_mulE = 1'b1;
    bus.mul_op     = 2'b00;
    bus.srcA_E     = 32'd3;
    bus.srcB_E     = 32'd5;
    bus.rdE        = 5'd7;
    sb_q.push_back('{res: 32'd15, rd: 5'd7, cyc: t0 + LAT});
    @(posedge clk); #1;
    bus.srcA_E = 32'hFFFF0000;
    repeat (LAT - 1) @(posedge clk);
    #1;
    bus.srcA_E = 32'd100;
    bus.srcB_E = 32'd200;
    bus.rdE    = 5'd8;
    sb_q.push_back('{res: 32'd20000, rd: 5'd8, cyc: t0 + 2 * LAT + 1});
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start_mulE = 1'b0;
    bus.srcA_E     = 32'h55555555;
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    check("scoreboard drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
